dtree_seq: RTL and testbench
============================

# dtree_seq

Sequential, programmable decision-tree classifier. It is the parametrised successor to the fixed combinational 30-feature/10-bit/5-bit-class DTree benchmark. Features stream in one per beat over a valid/ready handshake. The tree is held in a run-time-writable node table and walked one node per clock. The class is returned on a second valid/ready handshake. It sits between the dataset feature source and the result sink in ALS benchmark harnesses, where approximations can target comparator and table widths.

## Interface
- N_FEAT, 30: number of features per frame
- FEAT_W, 10: feature and threshold width
- CLASS_W, 5: class width; must be ≤ FEAT_W
- N_NODES, 64: node-table depth
- MAX_DEPTH, 16: walk-step limit
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid / in_ready  in / out  1  feature handshake
- in_data  in  FEAT_W  feature value
- in_last  in  1  final feature of the frame
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  clog2(N_NODES)  node index
- cfg_wdata  in  NODE_W  node word, where NODE_W = 1+FIDX_W+FEAT_W+2·NADDR_W
- cfg_ready  out  1  node-table writes are accepted this cycle
- out_valid / out_ready  out / in  1  result handshake
- out_class  out  CLASS_W  predicted class
- out_err  out  1  walk aborted by the depth limit

## Operation
- Node word layout, MSB first: is_leaf, feat_idx, threshold, left, right.
- Leaf class is threshold[CLASS_W-1:0].
- FSM has three states.
  - LOAD (reset state):
    - in_ready=1.
    - Each accepted beat writes feat[cnt] and increments cnt.
    - The frame closes on the beat with in_last=1, or on the N_FEAT-th beat, whichever comes first; then go to WALK with node=0, steps=0, cnt=0.
    - Features not written in the frame read as 0.
  - WALK:
    - in_ready=0.
    - Each cycle evaluates node[node].
    - If the node is a leaf, latch the class, set err=0, go to DONE.
    - If the node is internal, go to left when feat[feat_idx] ≤ threshold (unsigned), else to right; steps increments.
    - If steps reaches MAX_DEPTH without hitting a leaf, or feat_idx ≥ N_FEAT, or the child address ≥ N_NODES: class=0, err=1, go to DONE.
  - DONE:
    - out_valid=1; out_class and out_err are held stable.
    - On out_ready, clear all feature registers and return to LOAD.
- cfg_ready=1 only in LOAD with cnt=0; cfg_we is ignored otherwise.
- A write updates the table on the next edge, so the following frame sees it.
- Node table contents are undefined until written; the bench must program every reachable node.
- The node table is not cleared by rst. Features, cnt, FSM state and outputs are.

## Timing
- Reset values: in_ready=1, cfg_ready=1, out_valid=0, out_class=0, out_err=0, state=LOAD.
- rst asserted mid-frame or mid-walk abandons the frame immediately; no partial result is emitted.
- Latency: if the last-feature handshake is at edge E and the leaf sits at depth d (root = 0), out_valid rises after edge E+d+2.
- Error aborts assert out_valid after edge E+MAX_DEPTH+2 at most.
- out_valid, out_class and out_err stay stable until out_ready is sampled high.
- Back-pressure is unbounded.
- in_ready is 0 from the closing beat until the edge after the out handshake. No overlap of frames (throughput ≤ 1 frame per N+d+3 cycles).
- in_valid while in_ready=0 is ignored; the data is not consumed.

## Structure
- Package dtree_pkg holds:
  - the node-field offset and width localparam functions (FIDX_W = clog2(N_FEAT), NADDR_W = clog2(N_NODES), NODE_W)
  - the state enum {LOAD, WALK, DONE}
  - a node_t unpack function
- One sub-module, dtree_node_mem: the N_NODES×NODE_W register array with one synchronous write port and one combinational read port.
- The FSM, feature register file and comparator stay in dtree_seq.

## Test plan
- Stump (node0: feat 3 ≤ 512 → node1 leaf class 7, else node2 leaf class 21): feat3=512 gives class 7, feat3=513 gives class 21; out_valid after E+3, err=0.
- Short frame: in_last on beat 5, root tests feat 20 ≤ 0 → leaf 9. Unloaded feat20 reads 0, so class 9. The next frame of 30 beats with no in_last closes on beat 30.
- Loop (node0 → left=0, right=0, not leaf), MAX_DEPTH=16: out_err=1, out_class=0, out_valid after E+18.
- Back-pressure: hold out_ready=0 for 10 cycles. Outputs are stable, in_ready=0 and beats are not consumed. One cycle after out_ready=1, in_ready=1.
- Reprogramming: cfg_we while WALK is ignored (cfg_ready=0). A write in LOAD with cnt=0 changes the leaf class from 7 to 3, and the next frame returns 3.
- Reset asserted mid-WALK: out_valid=0 and in_ready=1 immediately. The node table is retained, so a repeat of the frame gives the original class.

Source files
------------

// File: rtl/dtree_pkg.sv
// dtree_pkg: shared definitions for the sequential decision-tree classifier.
//   - field-width and field-offset helpers for the packed node word
//     (MSB first: is_leaf, feat_idx, threshold, left, right)
//   - walk FSM state enum
//   - node_t record and its unpack function
package dtree_pkg;

    // Wide enough for any realistic node word / field; callers pad or slice.
    localparam int NODE_MAX_W  = 128;
    localparam int FIELD_MAX_W = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic                   is_leaf;
        logic [FIELD_MAX_W-1:0] feat_idx;
        logic [FIELD_MAX_W-1:0] threshold;
        logic [FIELD_MAX_W-1:0] left;
        logic [FIELD_MAX_W-1:0] right;
    } node_t;

    function automatic int fidx_w(input int n_feat);
        return (n_feat > 32'sd1) ? $clog2(n_feat) : 32'sd1;
    endfunction

    function automatic int naddr_w(input int n_nodes);
        return (n_nodes > 32'sd1) ? $clog2(n_nodes) : 32'sd1;
    endfunction

    function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
        return 32'sd1 + fidx_w(n_feat) + feat_w + 32'sd2 * naddr_w(n_nodes);
    endfunction

    function automatic int off_right();
        return 32'sd0;
    endfunction

    function automatic int off_left(input int naddr_bits);
        return naddr_bits;
    endfunction

    function automatic int off_thr(input int naddr_bits);
        return 32'sd2 * naddr_bits;
    endfunction

    function automatic int off_fidx(input int feat_bits, input int naddr_bits);
        return 32'sd2 * naddr_bits + feat_bits;
    endfunction

    function automatic int off_leaf(input int fidx_bits, input int feat_bits, input int naddr_bits);
        return 32'sd2 * naddr_bits + feat_bits + fidx_bits;
    endfunction

    function automatic logic [NODE_MAX_W-1:0] field_mask(input int bits);
        return (NODE_MAX_W'(1) << bits) - NODE_MAX_W'(1);
    endfunction

    // Split a zero-padded node word into its fields; each field is
    // right-aligned and zero-extended to FIELD_MAX_W.
    function automatic node_t node_unpack(input logic [NODE_MAX_W-1:0] word,
                                          input int fidx_bits,
                                          input int feat_bits,
                                          input int naddr_bits);
        node_t                 n;
        logic [NODE_MAX_W-1:0] tmp;
        tmp         = (word >> off_right()) & field_mask(naddr_bits);
        n.right     = tmp[FIELD_MAX_W-1:0];
        tmp         = (word >> off_left(naddr_bits)) & field_mask(naddr_bits);
        n.left      = tmp[FIELD_MAX_W-1:0];
        tmp         = (word >> off_thr(naddr_bits)) & field_mask(feat_bits);
        n.threshold = tmp[FIELD_MAX_W-1:0];
        tmp         = (word >> off_fidx(feat_bits, naddr_bits)) & field_mask(fidx_bits);
        n.feat_idx  = tmp[FIELD_MAX_W-1:0];
        tmp         = word >> off_leaf(fidx_bits, feat_bits, naddr_bits);
        n.is_leaf   = tmp[0];
        return n;
    endfunction

endpackage

// File: rtl/dtree_node_mem.sv
// dtree_node_mem: node table of the decision tree.
//   clk_i    : write clock
//   we_i     : write strobe (already qualified by the caller)
//   waddr_i  : write index
//   wdata_i  : packed node word
//   raddr_i  : read index (combinational read)
//   rdata_o  : packed node word at raddr_i
// The table has no reset: contents survive rst and are undefined until written.
module dtree_node_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 28,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dtree_seq.sv
// dtree_seq: sequential, programmable decision-tree classifier.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   : feature handshake, one feature per beat
//   in_data_i, in_last_i    : feature value, final feature of the frame
//   cfg_we_i/cfg_addr_i/
//   cfg_wdata_i/cfg_ready_o : node-table write port (accepted only between frames)
//   out_valid_o/out_ready_i : result handshake
//   out_class_o, out_err_o  : predicted class, walk aborted flag
// Flow: LOAD collects a frame, WALK visits one node per clock, DONE presents
// the result until it is taken. The result is registered once more after the
// walk decides, so out_valid rises two edges after the deciding node.
module dtree_seq
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = 30,
    parameter int FEAT_W    = 10,
    parameter int CLASS_W   = 5,
    parameter int N_NODES   = 64,
    parameter int MAX_DEPTH = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [FEAT_W-1:0]                        in_data_i,
    input  logic                                     in_last_i,
    input  logic                                     cfg_we_i,
    input  logic [naddr_w(N_NODES)-1:0]              cfg_addr_i,
    input  logic [node_w(N_FEAT,FEAT_W,N_NODES)-1:0] cfg_wdata_i,
    output logic                                     cfg_ready_o,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [CLASS_W-1:0]                       out_class_o,
    output logic                                     out_err_o
);

    localparam int FIDX_W  = fidx_w(N_FEAT);
    localparam int NADDR_W = naddr_w(N_NODES);
    localparam int NODE_W  = node_w(N_FEAT, FEAT_W, N_NODES);
    localparam int CNT_W   = fidx_w(N_FEAT);
    localparam int STEP_W  = $clog2(MAX_DEPTH + 32'sd1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(N_FEAT - 32'sd1);
    localparam logic [STEP_W-1:0]  STEP_LIMIT = STEP_W'(MAX_DEPTH);
    // One extra bit so the range checks never compare against an all-ones value.
    localparam logic [FIDX_W:0]    FIDX_LIMIT = (FIDX_W + 1)'(N_FEAT);
    localparam logic [NADDR_W:0]   ADDR_LIMIT = (NADDR_W + 1)'(N_NODES);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NADDR_W-1:0]   node_q, node_d;
    logic [STEP_W-1:0]    steps_q, steps_d;
    logic [CLASS_W-1:0]   class_q, class_d;
    logic                 err_q, err_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic [FEAT_W-1:0]    feat_q [N_FEAT];

    logic                 beat_s;
    logic                 close_s;
    logic                 handshake_s;
    logic [NODE_W-1:0]    node_word_s;
    logic [NODE_MAX_W-1:0] node_word_ext_s;
    node_t                node_s;
    logic                 node_unused_s;
    logic [FIDX_W-1:0]    fidx_s;
    logic [FEAT_W-1:0]    thr_s;
    logic [NADDR_W-1:0]   child_s;
    logic [FEAT_W-1:0]    feat_val_s;
    logic                 fidx_bad_s;
    logic                 child_bad_s;

    dtree_node_mem #(
        .DEPTH (N_NODES),
        .WIDTH (NODE_W),
        .AW    (NADDR_W)
    ) u_node_mem (
        .clk_i   (clk_i),
        .we_i    (cfg_we_i & cfg_ready_q),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_wdata_i),
        .raddr_i (node_q),
        .rdata_o (node_word_s)
    );

    assign node_word_ext_s = {{(NODE_MAX_W - NODE_W){1'b0}}, node_word_s};
    assign node_s          = node_unpack(node_word_ext_s, FIDX_W, FEAT_W, NADDR_W);
    // Padding bits of the wide record are intentionally dropped.
    assign node_unused_s   = ^node_s;
    assign fidx_s          = node_s.feat_idx[FIDX_W-1:0];
    assign thr_s           = node_s.threshold[FEAT_W-1:0];
    assign fidx_bad_s      = {1'b0, fidx_s} >= FIDX_LIMIT;

    // in_ready_q is only high in LOAD, out_valid_q only in DONE.
    assign beat_s      = in_valid_i & in_ready_q;
    assign close_s     = beat_s & (in_last_i | (cnt_q == CNT_LAST));
    assign handshake_s = out_valid_q & out_ready_i;

    // Feature selector: out-of-range indices read 0 and are flagged separately.
    always_comb begin
        feat_val_s = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (fidx_s == FIDX_W'(i)) begin
                feat_val_s = feat_q[i];
            end else begin
                feat_val_s = feat_val_s;
            end
        end
    end

    // Comparator: take the left child when feature <= threshold (unsigned).
    always_comb begin
        if (feat_val_s <= thr_s) begin
            child_s = node_s.left[NADDR_W-1:0];
        end else begin
            child_s = node_s.right[NADDR_W-1:0];
        end
        child_bad_s = {1'b0, child_s} >= ADDR_LIMIT;
    end

    // FSM next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        node_d   = node_q;
        steps_d  = steps_q;
        class_d  = class_q;
        err_d    = err_q;
        case (state_q)
            LOAD: begin
                if (close_s) begin
                    state_d = WALK;
                    cnt_d   = '0;
                    node_d  = '0;
                    steps_d = '0;
                end else if (beat_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WALK: begin
                if (node_s.is_leaf) begin
                    class_d = node_s.threshold[CLASS_W-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((steps_q == STEP_LIMIT) || fidx_bad_s || child_bad_s) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    node_d  = child_s;
                    steps_d = steps_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (handshake_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
        in_ready_d  = (state_d == LOAD);
        cfg_ready_d = (state_d == LOAD) && (cnt_d == '0);
        out_valid_d = (state_q == DONE) && !handshake_s;
    end

    // FSM state, walk pointer and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            node_q      <= '0;
            steps_q     <= '0;
            class_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            node_q      <= node_d;
            steps_q     <= steps_d;
            class_q     <= class_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Feature register file; cleared when a result is taken so short frames read 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_FEAT; i++) begin
                feat_q[i] <= '0;
            end
        end else if (handshake_s) begin
            for (int i = 0; i < N_FEAT; i++) begin
                feat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_FEAT; i++) begin
                if (beat_s && (cnt_q == CNT_W'(i))) begin
                    feat_q[i] <= in_data_i;
                end
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign cfg_ready_o = cfg_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_class_o = class_q;
    assign out_err_o   = err_q;

endmodule

// File: tb/tb_dtree_seq.sv
// Directed testbench for dtree_seq with hand-computed expectations.
module tb_dtree_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic        in_last;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [27:0] cfg_wdata;
    logic        cfg_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_class;
    logic        out_err;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          e_edge = 0;
    logic [9:0]  feat_tb [30];

    dtree_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_ready_o (cfg_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_class_o (out_class),
        .out_err_o   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] mk_node(input logic leaf, input logic [4:0] fidx,
                                            input logic [9:0] thr, input logic [5:0] l,
                                            input logic [5:0] r);
        return {leaf, fidx, thr, l, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [27:0] data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic clear_feats();
        for (int i = 0; i < 30; i++) feat_tb[i] = 10'd0;
    endtask

    // Sends beats 0..n-1; e_edge is the edge count of the closing handshake.
    task automatic send_frame(input int n, input bit use_last);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = feat_tb[i];
            in_last  = use_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        e_edge   = cyc;
    endtask

    // Waits for the result, checks it, optionally stalls, then takes it.
    task automatic collect(input string tag, input int exp_class, input int exp_err,
                           input int exp_lat, input int hold);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            lat = cyc - e_edge;
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_class"}, 32'(out_class), exp_class);
            check({tag, "_err"}, 32'(out_err), exp_err);
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                in_data  = 10'd999;
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_class"}, 32'(out_class), exp_class);
                check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_post_inrdy"}, 32'(in_ready), 32'd1);
            check({tag, "_post_cfgrdy"}, 32'(cfg_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit any_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 10'd0;
        in_last   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 6'd0;
        cfg_wdata = 28'd0;
        out_ready = 1'b0;
        clear_feats();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);

        // Stump: feat3 <= 512 -> leaf 7 else leaf 21; node3 leaf 9 for later
        cfg_write(6'd0, mk_node(1'b0, 5'd3, 10'd512, 6'd1, 6'd2));
        cfg_write(6'd1, mk_node(1'b1, 5'd0, 10'd7, 6'd0, 6'd0));
        cfg_write(6'd2, mk_node(1'b1, 5'd0, 10'd21, 6'd0, 6'd0));
        cfg_write(6'd3, mk_node(1'b1, 5'd0, 10'd9, 6'd0, 6'd0));

        clear_feats();
        feat_tb[3] = 10'd512;
        send_frame(4, 1'b1);
        collect("stump_eq", 7, 0, 3, 0);

        clear_feats();
        feat_tb[3] = 10'd513;
        send_frame(4, 1'b1);
        collect("stump_gt", 21, 0, 3, 0);

        // Root tests feat20 <= 0: left -> node3 (9), right -> node2 (21)
        cfg_write(6'd0, mk_node(1'b0, 5'd20, 10'd0, 6'd3, 6'd2));
        clear_feats();
        for (int i = 0; i < 5; i++) feat_tb[i] = 10'(100 + i);
        send_frame(5, 1'b1);
        collect("short", 9, 0, 3, 0);

        for (int i = 0; i < 30; i++) feat_tb[i] = 10'(i * 10 + 1);
        send_frame(30, 1'b0);
        check("full_closed_inrdy", 32'(in_ready), 32'd0);
        collect("full", 21, 0, 3, 0);

        // Features from the full frame must have been cleared
        clear_feats();
        for (int i = 0; i < 5; i++) feat_tb[i] = 10'(300 + i);
        send_frame(5, 1'b1);
        collect("short_again", 9, 0, 3, 0);

        // Self-loop at the root: depth-limit abort
        cfg_write(6'd0, mk_node(1'b0, 5'd0, 10'd0, 6'd0, 6'd0));
        clear_feats();
        send_frame(1, 1'b1);
        collect("loop", 0, 1, 18, 0);

        // Back-pressure with the stump restored
        cfg_write(6'd0, mk_node(1'b0, 5'd3, 10'd512, 6'd1, 6'd2));
        clear_feats();
        feat_tb[3] = 10'd100;
        send_frame(4, 1'b1);
        collect("bp", 7, 0, 3, 10);

        // Write attempted during WALK must be ignored
        clear_feats();
        send_frame(4, 1'b1);
        check("walk_cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_we    = 1'b1;
        cfg_addr  = 6'd1;
        cfg_wdata = mk_node(1'b1, 5'd0, 10'd3, 6'd0, 6'd0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        collect("walk_wr_same", 7, 0, 3, 0);
        send_frame(4, 1'b1);
        collect("walk_wr_next", 7, 0, 3, 0);

        // Write in LOAD with cnt=0 takes effect for the next frame
        check("load_cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_write(6'd1, mk_node(1'b1, 5'd0, 10'd3, 6'd0, 6'd0));
        send_frame(4, 1'b1);
        collect("reprog", 3, 0, 3, 0);

        // Reset mid-walk abandons the frame; the table is kept
        send_frame(4, 1'b1);
        check("mid_walk_inrdy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_walk_valid", 32'(out_valid), 32'd0);
        check("rst_walk_inrdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        any_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) any_valid = 1'b1;
        end
        check("rst_no_result", 32'(any_valid), 32'd0);
        send_frame(4, 1'b1);
        collect("after_rst", 3, 0, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
